aes_encipher_ctrl: RTL and testbench
====================================

// Module: aes_encipher_ctrl
// PURPOSE
//  Sequences one combinational encipher-round datapath over a full AES block
//  (AES-128: 10 rounds, AES-256: 14 rounds). Holds the 128-bit state, drives
//  round_type and key index per cycle, and returns the ciphertext via a ready/valid pair.
//  Sits between aes_core control and the key memory.
// PARAMETERS
//  AES_128_ROUNDS  10  rounds when keylen = 0
//  AES_256_ROUNDS  14  rounds when keylen = 1
// PORTS
//  clk           in   1    system clock; all state on rising edge
//  reset_n       in   1    asynchronous, active-low reset
//  next          in   1    start request; accepted only when ready = 1
//  keylen        in   1    0 = AES-128, 1 = AES-256; sampled on accept
//  block         in   128  plaintext, column-major, [127:120] = row0/col0
//  round         out  4    round key index to key memory
//  round_key     in   128  key for index 'round', valid combinationally in the same cycle
//  ready         out  1    1 = idle, can accept next
//  result        out  128  ciphertext; held until the next accept
//  result_valid  out  1    1 from completion until the next accept
//  abort         in   1    present only with AES_ENC_ABORT_EN
// BEHAVIOUR
//  Reset:
//   - state = 0, round = 0, ready = 1, result = 0, result_valid = 0, FSM = CTRL_IDLE.
//  FSM CTRL_IDLE -> CTRL_INIT -> CTRL_MAIN -> CTRL_FINAL -> CTRL_IDLE.
//  CTRL_IDLE:
//   - On next & ready: latch block into state, latch num_rounds from keylen.
//   - Clear result_valid, drop ready, go to CTRL_INIT.
//  CTRL_INIT (1 cycle):
//   - round = 0, round_type = INIT (AddRoundKey only); state <= datapath output.
//  CTRL_MAIN:
//   - round = 1..num_rounds-1, round_type = MAIN; state updated every cycle.
//   - Leave after round num_rounds-1.
//  CTRL_FINAL (1 cycle):
//   - round = num_rounds, round_type = FINAL; datapath output loaded into result.
//   - result_valid <= 1, ready <= 1, go to CTRL_IDLE.
//  Latency: result_valid rises num_rounds+1 cycles after the accept edge
//  (AES-128: 11, AES-256: 15). Back-to-back throughput is one block every N+2 cycles.
//  Round counter:
//   - 4-bit; increments only in CTRL_INIT/CTRL_MAIN; never wraps; cleared on accept.
//  round_type encoding: INIT = 0, MAIN = 1, FINAL = 2; never 3 (3 yields a zero datapath).
//  Boundaries:
//   - next while ready = 0 is ignored (no queueing).
//   - keylen or block changes mid-block are ignored.
//   - next in the completion cycle is not accepted; ready rises the following cycle.
//   - Reset mid-block returns to the reset values immediately; the partial state is discarded.
//   - In CTRL_IDLE, round = 0 and the datapath output is unused.
// CONFIGURATION
//  AES_ENC_ABORT_EN defined:
//   - abort = 1 in any non-idle state returns to CTRL_IDLE next cycle.
//   - ready = 1, result_valid stays 0, result keeps its previous value.
//   - abort in CTRL_IDLE has no effect.
//   - abort wins over FSM completion in CTRL_FINAL.
//  AES_ENC_ABORT_EN undefined:
//   - No abort port; a block always runs to completion.
// STRUCTURE
//  Shared package aes_pkg:
//   - round_type constants AES_INIT_ROUND, AES_MAIN_ROUND, AES_FINAL_ROUND (2-bit).
//   - FSM state constants CTRL_IDLE..CTRL_FINAL.
//   - AES_128_ROUNDS, AES_256_ROUNDS.
//  One sub-module: aes_encipher_round instance.
//   - Inputs: state bytes and round_key. Output: next state bytes.
//   - Only the FSM, the round counter and the state/result registers live here.
// TESTING
//  1. AES-128 FIPS-197 C.1: key 000102..0f, block 00112233445566778899aabbccddeeff
//     -> result 69c4e0d86a7b0430d8cdb78070b4c55a; result_valid 11 cycles after accept.
//  2. AES-256 FIPS-197 C.3: key 000102..1f, same block
//     -> 8ea2b7ca516745bfeafc49904b496089; latency 15 cycles; round sequence 0..14.
//  3. next pulsed every cycle while busy -> exactly one block processed;
//     next accepted only once ready = 1.
//  4. reset_n low at round 5 -> all outputs at reset values in the same cycle.
//     A following C.1 run is still correct.
//  5. Back-to-back C.1 then C.3 with keylen toggled mid-block
//     -> both results correct; result held stable between blocks.
//  6. (AES_ENC_ABORT_EN) abort at round 3 -> ready = 1 next cycle, result_valid = 0.
//     A following C.1 run is still correct.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES encipher definitions: round counts, round_type encoding and control FSM states.
package aes_pkg;

  localparam int unsigned AES_128_ROUNDS = 10;
  localparam int unsigned AES_256_ROUNDS = 14;
  localparam int unsigned AES_BLOCK_W    = 128;
  localparam int unsigned AES_ROUND_W    = 4;
  localparam int unsigned AES_RTYPE_W    = 2;

  localparam logic [AES_RTYPE_W-1:0] AES_INIT_ROUND  = 2'd0;
  localparam logic [AES_RTYPE_W-1:0] AES_MAIN_ROUND  = 2'd1;
  localparam logic [AES_RTYPE_W-1:0] AES_FINAL_ROUND = 2'd2;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'd0,
    CTRL_INIT  = 2'd1,
    CTRL_MAIN  = 2'd2,
    CTRL_FINAL = 2'd3
  } ctrl_state_e;

  // Multiply by x in GF(2^8), reduction polynomial 0x11b.
  function automatic logic [7:0] aes_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_encipher_round.sv
// One combinational AES encipher round; round_type selects AddRoundKey only, a full round,
// or the final round without MixColumns.
module aes_encipher_round
  import aes_pkg::*;
(
  input  logic [AES_RTYPE_W-1:0] round_type_i,
  input  aes_block_t             state_i,
  input  aes_block_t             round_key_i,
  output aes_block_t             state_o_c
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the byte offset of x is (255 - x) * 8.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {aes_xtime(a0) ^ aes_xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ aes_xtime(a1) ^ aes_xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ aes_xtime(a2) ^ aes_xtime(a3) ^ a3,
            aes_xtime(a0) ^ a0 ^ a1 ^ a2 ^ aes_xtime(a3)};
  endfunction

  aes_block_t sub_c;
  aes_block_t shift_c;
  aes_block_t mix_c;

  // Byte n = 4*col + row lives at [8*(15-n) +: 8].
  always_comb begin
    sub_c   = '0;
    shift_c = '0;
    mix_c   = '0;
    for (int i = 0; i < 16; i++) begin
      sub_c[8*(15-i) +: 8] = sbox(state_i[8*(15-i) +: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_c[8*(15-(4*c+r)) +: 8] = sub_c[8*(15-(4*((c+r)%4)+r)) +: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mix_c[32*(3-c) +: 32] = mix_column(shift_c[32*(3-c) +: 32]);
    end
  end

  always_comb begin
    state_o_c = '0;
    case (round_type_i)
      AES_INIT_ROUND:  state_o_c = state_i ^ round_key_i;
      AES_MAIN_ROUND:  state_o_c = mix_c ^ round_key_i;
      AES_FINAL_ROUND: state_o_c = shift_c ^ round_key_i;
      default:         state_o_c = '0;
    endcase
  end

endmodule

// File: rtl/aes_encipher_ctrl.sv
// Sequences one encipher-round datapath over a full AES-128/256 block with ready/valid handshake.
// Optional abort input is enabled by defining AES_ENC_ABORT_EN.
module aes_encipher_ctrl
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   next,
  input  logic                   keylen,
  input  logic [AES_BLOCK_W-1:0] block,
  output logic [AES_ROUND_W-1:0] round,
  input  logic [AES_BLOCK_W-1:0] round_key,
  output logic                   ready,
  output logic [AES_BLOCK_W-1:0] result,
  output logic                   result_valid
`ifdef AES_ENC_ABORT_EN
  ,
  input  logic                   abort
`endif
);

  ctrl_state_e            fsm_q, fsm_d;
  aes_block_t             aes_state_q, aes_state_d;
  aes_block_t             result_q, result_d;
  logic [AES_ROUND_W-1:0] round_q, round_d;
  logic [AES_ROUND_W-1:0] num_rounds_q, num_rounds_d;
  logic                   ready_q, ready_d;
  logic                   valid_q, valid_d;
  logic [AES_RTYPE_W-1:0] round_type_c;
  aes_block_t             dp_out_c;

  aes_encipher_round u_round (
    .round_type_i (round_type_c),
    .state_i      (aes_state_q),
    .round_key_i  (round_key),
    .state_o_c    (dp_out_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q        <= CTRL_IDLE;
      aes_state_q  <= '0;
      result_q     <= '0;
      round_q      <= '0;
      num_rounds_q <= '0;
      ready_q      <= 1'b1;
      valid_q      <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      aes_state_q  <= aes_state_d;
      result_q     <= result_d;
      round_q      <= round_d;
      num_rounds_q <= num_rounds_d;
      ready_q      <= ready_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    fsm_d        = fsm_q;
    aes_state_d  = aes_state_q;
    result_d     = result_q;
    round_d      = round_q;
    num_rounds_d = num_rounds_q;
    ready_d      = ready_q;
    valid_d      = valid_q;
    round_type_c = AES_INIT_ROUND;

    case (fsm_q)
      CTRL_IDLE: begin
        if (next && ready_q) begin
          aes_state_d  = block;
          num_rounds_d = keylen ? AES_ROUND_W'(AES_256_ROUNDS) : AES_ROUND_W'(AES_128_ROUNDS);
          round_d      = '0;
          valid_d      = 1'b0;
          ready_d      = 1'b0;
          fsm_d        = CTRL_INIT;
        end
      end
      CTRL_INIT: begin
        round_type_c = AES_INIT_ROUND;
        aes_state_d  = dp_out_c;
        round_d      = round_q + 4'd1;
        fsm_d        = CTRL_MAIN;
      end
      CTRL_MAIN: begin
        round_type_c = AES_MAIN_ROUND;
        aes_state_d  = dp_out_c;
        round_d      = round_q + 4'd1;
        if (round_q == (num_rounds_q - 4'd1)) begin
          fsm_d = CTRL_FINAL;
        end
      end
      CTRL_FINAL: begin
        round_type_c = AES_FINAL_ROUND;
        result_d     = dp_out_c;
        valid_d      = 1'b1;
        ready_d      = 1'b1;
        round_d      = '0;
        fsm_d        = CTRL_IDLE;
      end
      default: fsm_d = CTRL_IDLE;
    endcase

`ifdef AES_ENC_ABORT_EN
    // Abort outranks completion; result keeps the last finished block.
    if (abort && (fsm_q != CTRL_IDLE)) begin
      fsm_d    = CTRL_IDLE;
      result_d = result_q;
      valid_d  = 1'b0;
      ready_d  = 1'b1;
      round_d  = '0;
    end
`endif
  end

  assign round        = round_q;
  assign ready        = ready_q;
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_aes_encipher_ctrl.sv
// Scoreboard bench for aes_encipher_ctrl using the FIPS-197 C.1 / C.3 vectors; the bench plays key memory.
module tb_aes_encipher_ctrl;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  localparam logic [2047:0] SBOX_TB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef struct {
    logic [127:0] res;
    int           acc;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         next;
  logic         keylen;
  logic [127:0] block;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic [127:0] result;
  logic         result_valid;
`ifdef AES_ENC_ABORT_EN
  logic         abort;
`endif

  logic [127:0] rk128 [0:10];
  logic [127:0] rk256 [0:14];
  logic         cur_is256;
  exp_t         exp_q[$];
  int           n_pass = 0;
  int           n_total = 0;
  int           done_cnt = 0;
  int           exp_done = 0;
  int           cyc = 0;

  aes_encipher_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .next         (next),
    .keylen       (keylen),
    .block        (block),
    .round        (round),
    .round_key    (round_key),
    .ready        (ready),
    .result       (result),
    .result_valid (result_valid)
`ifdef AES_ENC_ABORT_EN
    ,
    .abort        (abort)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key memory: round key for the current index, valid in the same cycle.
  always_comb begin
    round_key = '0;
    if (cur_is256) begin
      if (round <= 4'd14) round_key = rk256[round];
    end else if (round <= 4'd10) begin
      round_key = rk128[round];
    end
  end

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [2047:0] t;
    t = SBOX_TB;
    return t[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    int          nr;
    nr   = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r <= nr; r++) begin
      if (nk == 4) rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic fail_now(input string name, input logic [127:0] act);
    n_total++;
    $display("FAIL %s: got %h (cycle %0d)", name, act, cyc);
  endtask

  // Issues one block; returns just after the accept edge with acc = accept cycle.
  task automatic run_block(input logic [127:0] blk, input bit is256, input logic [127:0] exp_res,
                           input bit pulse, input bit scramble, output int acc);
    int n;
    n   = 0;
    acc = -1;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) begin
      fail_now("ready_timeout", 128'(ready));
      return;
    end
    cur_is256 = is256;
    next      = 1'b1;
    keylen    = is256;
    block     = blk;
    acc       = cyc + 1;
    exp_q.push_back('{exp_res, acc, is256 ? 15 : 11});
    exp_done++;
    @(posedge clk); #1;
    check("ready_low_after_accept", 128'(ready), 128'(0));
    next = pulse;
    if (scramble) begin
      keylen = ~is256;
      block  = ~blk;
    end
  endtask

  task automatic wait_done(input bit pulse);
    int n;
    n = 0;
    while (!result_valid && n < 40) begin
      next = pulse;
      @(posedge clk); #1;
      n++;
    end
    next = 1'b0;
    if (!result_valid) fail_now("done_timeout", 128'(result_valid));
  endtask

  task automatic wait_round(input logic [3:0] target);
    int n;
    n = 0;
    while (round != target && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (round != target) fail_now("round_timeout", 128'(round));
  endtask

  // Monitor: pops the scoreboard on each result_valid rise, otherwise result must hold.
  initial begin : monitor
    logic         pv;
    logic [127:0] pr;
    exp_t         e;
    pv = 1'b0;
    pr = '0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (result_valid && !pv) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            fail_now("unexpected_result", result);
          end else begin
            e = exp_q.pop_front();
            check("result", result, e.res);
            check("latency", 128'(cyc - e.acc), 128'(e.lat));
          end
        end else begin
          check("result_hold", result, pr);
        end
      end
      pv = result_valid;
      pr = result;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int           acc1;
    int           acc2;
    logic [59:0]  seq_act;
    logic [59:0]  seq_req;
    reset_n   = 1'b0;
    next      = 1'b0;
    keylen    = 1'b0;
    block     = '0;
    cur_is256 = 1'b0;
`ifdef AES_ENC_ABORT_EN
    abort     = 1'b0;
`endif
    expand(KEY128, 4);
    expand(KEY256, 8);

    repeat (3) @(posedge clk);
    #1;
    check("reset_round", 128'(round), 128'(0));
    check("reset_ready", 128'(ready), 128'(1));
    check("reset_result", result, 128'(0));
    check("reset_valid", 128'(result_valid), 128'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // C.1 AES-128
    run_block(PT, 1'b0, CT128, 1'b0, 1'b0, acc1);
    wait_done(1'b0);

    // C.3 AES-256 with round index sequence 0..14
    run_block(PT, 1'b1, CT256, 1'b0, 1'b0, acc1);
    for (int j = 0; j < 15; j++) begin
      seq_act[4*j +: 4] = round;
      seq_req[4*j +: 4] = 4'(j);
      @(posedge clk); #1;
    end
    check("round_sequence", 128'(seq_act), 128'(seq_req));
    wait_done(1'b0);

    // next held high through the whole block: exactly one block runs
    run_block(PT, 1'b0, CT128, 1'b1, 1'b0, acc1);
    wait_done(1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("pulse_ready_idle", 128'(ready), 128'(1));
    check("pulse_single_block", 128'(done_cnt), 128'(exp_done));

    // reset at round 5 discards the block
    run_block(PT, 1'b0, CT128, 1'b0, 1'b0, acc1);
    wait_round(4'd5);
    reset_n = 1'b0;
    #1;
    check("midreset_round", 128'(round), 128'(0));
    check("midreset_ready", 128'(ready), 128'(1));
    check("midreset_result", result, 128'(0));
    check("midreset_valid", 128'(result_valid), 128'(0));
    exp_q.delete();
    exp_done--;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_block(PT, 1'b0, CT128, 1'b0, 1'b0, acc1);
    wait_done(1'b0);

    // back-to-back C.1 then C.3, keylen and block disturbed mid-block
    run_block(PT, 1'b0, CT128, 1'b0, 1'b1, acc1);
    run_block(PT, 1'b1, CT256, 1'b0, 1'b1, acc2);
    check("throughput", 128'(acc2 - acc1), 128'(12));
    check("result_held_across_accept", result, CT128);
    wait_done(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("result_held_idle", result, CT256);

`ifdef AES_ENC_ABORT_EN
    // abort at round 3 returns to idle without a result
    run_block(PT, 1'b0, CT128, 1'b0, 1'b0, acc1);
    wait_round(4'd3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_ready", 128'(ready), 128'(1));
    check("abort_valid", 128'(result_valid), 128'(0));
    check("abort_result_kept", result, CT256);
    exp_q.delete();
    exp_done--;
    run_block(PT, 1'b0, CT128, 1'b0, 1'b0, acc1);
    wait_done(1'b0);
`endif

    repeat (20) @(posedge clk);
    #1;
    check("completions", 128'(done_cnt), 128'(exp_done));
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
